// File: rtl/swap_scheduler_pkg.sv
// Shared definitions for the swap scheduler.
//   state_e  : scheduler FSM state encoding
//   CMD_SWAP : swap engine command that starts a swap
//   CMD_IDLE : swap engine command driven in every other state
//   is_wait  : true for the states that count towards the timeout
package swap_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StIssue    = 3'd2,
    StWaitBusy = 3'd3,
    StWaitIrq  = 3'd4,
    StWaitClr  = 3'd5,
    StDone     = 3'd6
  } state_e;

  localparam logic [3:0] CMD_SWAP = 4'h5;
  localparam logic [3:0] CMD_IDLE = 4'h0;

  function automatic logic is_wait(input state_e s);
    return (s == StWaitBusy) || (s == StWaitIrq) || (s == StWaitClr);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
//   req    : request vector, bit i for requester i
//   last   : index of the requester that won most recently
//   winner : one-hot winner, zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      // On a tie the requester that did not win last time goes first.
      2'b11:   winner = last ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/swap_scheduler.sv
// Arbitrates two requesters onto a single swap engine and sequences one swap
// at a time: latch operands, issue the start command, then follow the engine
// busy/interrupt handshake, with a timeout guarding every wait state.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req                 : per-requester level request, held until done
//   req_read_addr/...   : packed per-requester operands (requester i in slice i)
//   gnt                 : one-hot grant, high from issue until done
//   done                : one-cycle completion pulse to the granted requester
//   err                 : one-cycle timeout pulse
//   busy                : FSM not idle
//   read_addr/...       : registered operands to the swap engine
//   command             : swap engine command
//   cmd_swap, interupt  : swap engine busy and completion flags
module swap_scheduler
  import swap_scheduler_pkg::*;
#(
  parameter int unsigned ADDR    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [2*(ADDR+1)-1:0] req_read_addr,
  input  logic [2*(ADDR+1)-1:0] req_write_addr,
  input  logic [3:0]            req_chunks,
  input  logic [1:0]            req_sel_cd,
  input  logic [1:0]            req_sel_ab,
  input  logic                  cmd_swap,
  input  logic                  interupt,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic                  err,
  output logic                  busy,
  output logic [ADDR:0]         read_addr,
  output logic [ADDR:0]         write_addr,
  output logic [1:0]            numbr_of_chunk,
  output logic                  select_Ram_C_Or_D,
  output logic                  select_Ram_A_Or_B,
  output logic [3:0]            command
);

  localparam int unsigned AW = ADDR + 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CntLimit = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntMax   = {CW{1'b1}};

  state_e          state_q, state_d;
  logic [1:0]      winner_q, winner_d;
  logic            last_q, last_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [AW-1:0]   read_addr_q, read_addr_d;
  logic [AW-1:0]   write_addr_q, write_addr_d;
  logic [1:0]      chunks_q, chunks_d;
  logic            sel_cd_q, sel_cd_d;
  logic            sel_ab_q, sel_ab_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      rr_winner;
  logic            timeout_hit;
  logic            sel_hi;

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .last   (last_q),
    .winner (rr_winner)
  );

  assign sel_hi      = winner_q[1];
  assign timeout_hit = is_wait(state_q) && (cnt_q == CntLimit);

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    chunks_d     = chunks_q;
    sel_cd_d     = sel_cd_q;
    sel_ab_d     = sel_ab_q;
    cnt_d        = cnt_q;

    // Wait states count up, saturating so a stuck engine can never wrap.
    if (is_wait(state_q) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      StIdle: begin
        if (|req) begin
          winner_d = rr_winner;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        read_addr_d  = sel_hi ? req_read_addr[2*AW-1:AW]  : req_read_addr[AW-1:0];
        write_addr_d = sel_hi ? req_write_addr[2*AW-1:AW] : req_write_addr[AW-1:0];
        chunks_d     = sel_hi ? req_chunks[3:2] : req_chunks[1:0];
        sel_cd_d     = sel_hi ? req_sel_cd[1] : req_sel_cd[0];
        sel_ab_d     = sel_hi ? req_sel_ab[1] : req_sel_ab[0];
        gnt_d        = winner_q;
        last_d       = winner_q[1];
        state_d      = StIssue;
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (timeout_hit) begin
          gnt_d   = 2'b00;
          state_d = StIdle;
        end else if (cmd_swap) begin
          state_d = StWaitIrq;
        end
      end
      StWaitIrq: begin
        if (timeout_hit) begin
          gnt_d   = 2'b00;
          state_d = StIdle;
        end else if (interupt) begin
          state_d = StWaitClr;
        end
      end
      StWaitClr: begin
        // A lingering second interrupt cycle lands here and is ignored.
        if (timeout_hit) begin
          gnt_d   = 2'b00;
          state_d = StIdle;
        end else if (!cmd_swap) begin
          state_d = StDone;
        end
      end
      StDone: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      winner_q     <= 2'b00;
      last_q       <= 1'b1;
      gnt_q        <= 2'b00;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      chunks_q     <= 2'b00;
      sel_cd_q     <= 1'b0;
      sel_ab_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      chunks_q     <= chunks_d;
      sel_cd_q     <= sel_cd_d;
      sel_ab_q     <= sel_ab_d;
      cnt_q        <= cnt_d;
    end
  end

  // Decoded straight from state so reset clears them without waiting a clock.
  assign command           = (state_q == StIssue) ? CMD_SWAP : CMD_IDLE;
  assign done              = (state_q == StDone) ? winner_q : 2'b00;
  assign err               = timeout_hit;
  assign busy              = (state_q != StIdle);
  assign gnt               = gnt_q;
  assign read_addr         = read_addr_q;
  assign write_addr        = write_addr_q;
  assign numbr_of_chunk    = chunks_q;
  assign select_Ram_C_Or_D = sel_cd_q;
  assign select_Ram_A_Or_B = sel_ab_q;

endmodule
